wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stream and the long-latency multiply/divide unit (MDU) result stream. Sits between the WB stage, the MDU result interface and the register file. Tracks outstanding MDU destinations in a scoreboard so that decode can stall on RAW and WAW hazards. Pipeline writes always win. A bounded starvation counter forces a pipeline bubble so that a waiting MDU result commits.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 3, register index width (2^ADDR_W registers)
- STARVE_MAX, 4, consecutive denied cycles before stall_req asserts (≥1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pl_wb_en  in  1  pipeline writeback valid (not stallable)
- pl_wb_dest  in  ADDR_W  pipeline destination
- pl_wb_data  in  DATA_W  pipeline data
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  MDU result accepted this cycle (combinational)
- mdu_dest  in  ADDR_W  MDU destination
- mdu_data  in  DATA_W  MDU data
- mdu_issue  in  1  MDU operation issued from decode
- mdu_issue_dest  in  ADDR_W  destination of issued MDU op
- stall_req  out  1  request to the hazard unit to inject an upstream bubble
- busy  out  2^ADDR_W  scoreboard pending-write bits
- rf_we  out  1  register-file write enable (registered)
- rf_addr  out  ADDR_W  register-file write address (registered)
- rf_data  out  DATA_W  register-file write data (registered)

## Operation
- Grant is evaluated every cycle:
  - pl_wb_en=1: pipeline granted; mdu_ready=0.
  - pl_wb_en=0 and mdu_valid=1: mdu_ready=1 and MDU granted.
  - Otherwise nothing is granted.
- On a granted write, rf_addr and rf_data load from the winner next edge. rf_we is set to 1 unless the destination is 0.
- Writes to register 0 are dropped (rf_we=0) but still complete the handshake and still clear the scoreboard.
- With no grant, rf_we=0. rf_addr and rf_data hold.
- FSM:
  - IDLE: mdu_valid=0 or MDU granted. Counter=0.
  - WAIT: mdu_valid=1 and denied. Counter increments by 1 per denied cycle, saturating at STARVE_MAX.
  - FORCE: entered when counter reaches STARVE_MAX. stall_req=1 while in FORCE.
- Transitions:
  - IDLE→WAIT on a denied valid.
  - WAIT→FORCE on the counter hitting STARVE_MAX.
  - WAIT or FORCE→IDLE on an MDU grant.
  - mdu_valid dropping without a grant is illegal. The bench flags it; the RTL returns to IDLE.
- MDU inputs must stay stable while mdu_valid=1 and mdu_ready=0.
- Scoreboard:
  - mdu_issue sets busy[mdu_issue_dest].
  - An MDU grant clears busy[mdu_dest].
  - Set and clear on the same index in the same cycle: set wins.
  - Issue to register 0 is ignored.
- Pipeline writes never touch the scoreboard.
- Pipeline and MDU targeting the same register in one cycle: the pipeline writes first and the MDU commits later. Hazard avoidance is decode's job, using busy.

## Timing
- Reset values: rf_we=0, rf_addr=0, rf_data=0, busy=0, stall_req=0, FSM=IDLE, counter=0.
- mdu_ready is combinational from pl_wb_en and mdu_valid.
- Handshake completes when mdu_valid and mdu_ready are both 1 at a rising edge.
- Write latency is 1 cycle: a grant at edge N gives rf_we/rf_addr/rf_data valid after edge N.
- busy updates 1 cycle after issue or grant.
- stall_req is registered and asserts 1 cycle after the STARVE_MAX-th denied cycle.
- stall_req deasserts in the cycle after the MDU grant.
- Reset asserted mid-operation: all state clears immediately. A pending MDU result must be re-presented after reset.

## Configuration
- Macro WB_ARB_SCOREBOARD_EN.
- Defined: scoreboard is present as described above.
- Undefined:
  - busy is tied to 0.
  - mdu_issue and mdu_issue_dest are ignored.
  - No scoreboard flops are built.
  - Decode must serialise MDU ops itself.
- Arbitration and FSM are identical in both builds.

## Structure
- Shared package holds:
  - DATA_W and ADDR_W constants.
  - FSM state enum {IDLE, WAIT, FORCE}.
  - Register-0 index constant.
- One natural sub-module: wb_scoreboard, holding the busy vector with set/clear ports. It is instantiated only under WB_ARB_SCOREBOARD_EN.

## Test plan
- **Reset:** rst pulse mid-traffic → all outputs 0 and FSM in IDLE in the same cycle.
- **Pipeline only:** pl_wb_en=1, dest=5, data=0x1234 → next cycle rf_we=1, rf_addr=5, rf_data=0x1234.
- **MDU idle port:** mdu_valid=1, dest=3, data=0xBEEF, pl_wb_en=0 → mdu_ready=1 same cycle; next cycle rf_addr=3, rf_data=0xBEEF; busy[3] clears.
- **Starvation:** STARVE_MAX=4, pl_wb_en=1 continuously with MDU valid → stall_req=1 after the 4th denied cycle. Then drop pl_wb_en → MDU granted, and stall_req=0 the following cycle.
- **Scoreboard collision:** mdu_issue dest=2 in the same cycle as an MDU grant of dest=2 → busy[2] stays 1. Issue to dest=0 → busy unchanged.
- **Register 0:** MDU result to dest=0 → handshake completes and rf_we stays 0. Pipeline write to dest=0 → rf_we=0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and FSM state type for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int REG_ZERO = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bit per register for outstanding MDU operations.
// When set and clear hit the same index in one cycle, the set wins.
module wb_scoreboard #(
   parameter int ADDR_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_idx,
   input  logic                     clr_en,
   input  logic [ADDR_W-1:0]        clr_idx,
   output logic [(1<<ADDR_W)-1:0]   busy
);

   localparam int NUM_REGS = 1 << ADDR_W;

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) begin
         set_mask[set_idx] = 1'b1;
      end
      if (clr_en) begin
         clr_mask[clr_idx] = 1'b1;
      end
   end

   // The set mask is OR-ed in after the clear, so the set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~clr_mask) | set_mask;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the pipeline writeback and the MDU.
// The MDU scoreboard is built only when WB_ARB_SCOREBOARD_EN is defined.
module wb_port_arbiter #(
   parameter int DATA_W     = wb_port_arbiter_pkg::DATA_W,
   parameter int ADDR_W     = wb_port_arbiter_pkg::ADDR_W,
   parameter int STARVE_MAX = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pl_wb_en,
   input  logic [ADDR_W-1:0]        pl_wb_dest,
   input  logic [DATA_W-1:0]        pl_wb_data,
   input  logic                     mdu_valid,
   output logic                     mdu_ready,
   input  logic [ADDR_W-1:0]        mdu_dest,
   input  logic [DATA_W-1:0]        mdu_data,
   input  logic                     mdu_issue,
   input  logic [ADDR_W-1:0]        mdu_issue_dest,
   output logic                     stall_req,
   output logic [(1<<ADDR_W)-1:0]   busy,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_addr,
   output logic [DATA_W-1:0]        rf_data
);

   import wb_port_arbiter_pkg::*;

   localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

   logic              grant_pl;
   logic              grant_mdu;
   logic              denied;
   logic [ADDR_W-1:0] win_dest;
   logic [DATA_W-1:0] win_data;

   arb_state_t        state;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_inc;

   // Pipeline always wins; the MDU only gets an otherwise idle port.
   always_comb begin
      grant_pl  = pl_wb_en;
      grant_mdu = !pl_wb_en && mdu_valid;
      denied    = pl_wb_en && mdu_valid;
      win_dest  = grant_pl ? pl_wb_dest : mdu_dest;
      win_data  = grant_pl ? pl_wb_data : mdu_data;
      count_inc = (count == CNT_MAX) ? CNT_MAX : count + CNT_W'(1);
   end

   assign mdu_ready = grant_mdu;

   // Register-0 writes still load address/data but never raise the enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we   <= 1'b0;
         rf_addr <= '0;
         rf_data <= '0;
      end else if (grant_pl || grant_mdu) begin
         rf_we   <= (win_dest != ZERO_IDX);
         rf_addr <= win_dest;
         rf_data <= win_data;
      end else begin
         rf_we   <= 1'b0;
      end
   end

   // Starvation tracker: any cycle that is not a denied MDU request (grant or
   // an illegally dropped valid) returns to IDLE and releases the stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         stall_req <= 1'b0;
      end else begin
         case (state)
            IDLE, WAIT: begin
               if (denied) begin
                  count <= count_inc;
                  if (count_inc == CNT_MAX) begin
                     state     <= FORCE;
                     stall_req <= 1'b1;
                  end else begin
                     state     <= WAIT;
                     stall_req <= 1'b0;
                  end
               end else begin
                  state     <= IDLE;
                  count     <= '0;
                  stall_req <= 1'b0;
               end
            end
            FORCE: begin
               if (!denied) begin
                  state     <= IDLE;
                  count     <= '0;
                  stall_req <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               count     <= '0;
               stall_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef WB_ARB_SCOREBOARD_EN
   logic issue_set;

   assign issue_set = mdu_issue && (mdu_issue_dest != ZERO_IDX);

   wb_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk     (clk),
      .rst     (rst),
      .set_en  (issue_set),
      .set_idx (mdu_issue_dest),
      .clr_en  (grant_mdu),
      .clr_idx (mdu_dest),
      .busy    (busy)
   );
`else
   // Without a scoreboard decode serialises MDU ops, so issue info is dropped.
   logic unused_issue;

   assign unused_issue = ^{mdu_issue, mdu_issue_dest};
   assign busy         = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter using a reference model and expectation queue.
// Scoreboard expectations follow WB_ARB_SCOREBOARD_EN as seen by this file.
module tb_wb_port_arbiter;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int NR = 1 << AW;
   localparam int SM = 4;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [NR-1:0] busy;
      logic          stall;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pl_wb_en = 1'b0;
   logic [AW-1:0] pl_wb_dest = '0;
   logic [DW-1:0] pl_wb_data = '0;
   logic          mdu_valid = 1'b0;
   logic          mdu_ready;
   logic [AW-1:0] mdu_dest = '0;
   logic [DW-1:0] mdu_data = '0;
   logic          mdu_issue = 1'b0;
   logic [AW-1:0] mdu_issue_dest = '0;
   logic          stall_req;
   logic [NR-1:0] busy;
   logic          rf_we;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;

   int            checks   = 0;
   int            failures = 0;

   int            m_cnt  = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic [NR-1:0] m_busy = '0;
   exp_t          exp_q[$];

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .STARVE_MAX (SM)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pl_wb_en       (pl_wb_en),
      .pl_wb_dest     (pl_wb_dest),
      .pl_wb_data     (pl_wb_data),
      .mdu_valid      (mdu_valid),
      .mdu_ready      (mdu_ready),
      .mdu_dest       (mdu_dest),
      .mdu_data       (mdu_data),
      .mdu_issue      (mdu_issue),
      .mdu_issue_dest (mdu_issue_dest),
      .stall_req      (stall_req),
      .busy           (busy),
      .rf_we          (rf_we),
      .rf_addr        (rf_addr),
      .rf_data        (rf_data)
   );

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_rf_we"},   32'(rf_we),     32'd0);
      checkOutput({tag, "_rf_addr"}, 32'(rf_addr),   32'd0);
      checkOutput({tag, "_rf_data"}, 32'(rf_data),   32'd0);
      checkOutput({tag, "_busy"},    32'(busy),      32'd0);
      checkOutput({tag, "_stall"},   32'(stall_req), 32'd0);
   endtask

   task automatic resetModel();
      m_cnt  = 0;
      m_addr = '0;
      m_data = '0;
      m_busy = '0;
      exp_q.delete();
   endtask

   // Drive one cycle, predict the post-edge outputs, then compare after the edge.
   task automatic applyStimulus(input logic pl, input logic [AW-1:0] pd, input logic [DW-1:0] pdat,
                                input logic mv, input logic [AW-1:0] md, input logic [DW-1:0] mdat,
                                input logic iss, input logic [AW-1:0] idest);
      exp_t e;
      exp_t got;
      pl_wb_en       = pl;
      pl_wb_dest     = pd;
      pl_wb_data     = pdat;
      mdu_valid      = mv;
      mdu_dest       = md;
      mdu_data       = mdat;
      mdu_issue      = iss;
      mdu_issue_dest = idest;
      #1;
      checkOutput("mdu_ready", 32'(mdu_ready), 32'(!pl && mv));

      if (pl) begin
         e.we   = (pd != 0);
         m_addr = pd;
         m_data = pdat;
      end else if (mv) begin
         e.we   = (md != 0);
         m_addr = md;
         m_data = mdat;
      end else begin
         e.we   = 1'b0;
      end
      if (pl && mv) begin
         m_cnt = (m_cnt < SM) ? m_cnt + 1 : SM;
      end else begin
         m_cnt = 0;
      end
`ifdef WB_ARB_SCOREBOARD_EN
      if (!pl && mv) m_busy[md] = 1'b0;
      if (iss && idest != 0) m_busy[idest] = 1'b1;
`else
      m_busy = '0;
`endif
      e.addr  = m_addr;
      e.data  = m_data;
      e.busy  = m_busy;
      e.stall = (m_cnt == SM);
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checkOutput("queue_underflow", 32'd0, 32'd1);
      end else begin
         got = exp_q.pop_front();
         checkOutput("rf_we",     32'(rf_we),     32'(got.we));
         checkOutput("rf_addr",   32'(rf_addr),   32'(got.addr));
         checkOutput("rf_data",   32'(rf_data),   32'(got.data));
         checkOutput("busy",      32'(busy),      32'(got.busy));
         checkOutput("stall_req", 32'(stall_req), 32'(got.stall));
      end
   endtask

   initial begin
      logic          r_mv;
      logic [AW-1:0] r_md;
      logic [DW-1:0] r_mdat;
      logic          r_pl;
      logic          pending;

      #2;
      checkResetOutputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      applyStimulus(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0);

      // Starvation: five denied cycles, stall from the fourth, then release.
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 3'(i + 1), 16'(16'h0111 * (i + 1)), 1'b1, 3'd6, 16'h5A5A, 1'b0, 3'd0);
      end
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h5A5A, 1'b0, 3'd0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);

      // Set/clear collision on one index, then an ignored issue to register 0.
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'hC0DE, 1'b1, 3'd2);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0);

      // Register 0 targets from both sources.
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h0077, 1'b0, 3'd0);
      applyStimulus(1'b1, 3'd0, 16'h4321, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);

      // Random legal traffic; a denied MDU result is held until granted.
      pending = 1'b0;
      r_mv    = 1'b0;
      r_md    = '0;
      r_mdat  = '0;
      for (int i = 0; i < 80; i++) begin
         if (!pending) begin
            r_mv   = ($urandom_range(0, 1) == 1);
            r_md   = 3'($urandom_range(0, 7));
            r_mdat = 16'($urandom);
         end
         r_pl = ($urandom_range(0, 3) != 0);
         applyStimulus(r_pl, 3'($urandom_range(0, 7)), 16'($urandom),
                       r_mv, r_md, r_mdat,
                       ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
         pending = r_mv && r_pl;
      end
      applyStimulus(1'b0, 3'd0, 16'h0000, r_mv, r_md, r_mdat, 1'b0, 3'd0);

      // Reset in the middle of a starvation episode.
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 3'd7, 16'h7777, 1'b1, 3'd4, 16'hFACE, 1'b0, 3'd0);
      end
      rst = 1'b1;
      #1;
      checkResetOutputs("midreset");
      resetModel();
      pl_wb_en  = 1'b0;
      mdu_valid = 1'b0;
      mdu_issue = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'hFACE, 1'b0, 3'd0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
